// File: rtl/pc_npc_unit.sv
// pc_npc_unit: PC/nPC pair for the fetch stage with delayed/immediate
// redirects, a load-enable stall and a small circular return-address stack.
module pc_npc_unit #(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_PC  = '0,
  parameter logic [WIDTH-1:0]  INC       = WIDTH'(4),
  parameter int                RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         le_pc,
  input  logic                         redirect_valid,
  input  logic [WIDTH-1:0]             redirect_target,
  input  logic                         redirect_delayed,
  input  logic                         call_push,
  input  logic                         ret_pop,
  output logic [WIDTH-1:0]             pc_out,
  output logic [WIDTH-1:0]             npc_out,
  output logic [WIDTH-1:0]             ras_top,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, npc_q;
  logic [WIDTH-1:0] pc_d, npc_d;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [CNT_W-1:0] ras_cnt;
  logic             ovf_q, unf_q;
  logic             ovf_d, unf_d;
  logic             do_push, do_pop, take;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] push_val;

  assign pc_out        = pc_q;
  assign npc_out       = npc_q;
  assign ras_count     = ras_cnt;
  assign ras_empty     = (ras_cnt == '0);
  assign ras_full      = (ras_cnt == FULL_CNT);
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
  // Return address skips the delay slot, so it is two slots past the current PC.
  assign push_val      = npc_q + INC;

  // Top of stack reads from registered state; empty stack reads as zero.
  always_comb begin
    ras_top = '0;
    if (!ras_empty) ras_top = ras_mem[ras_ptr];
  end

  // Decide next PC/nPC and stack action; ret_pop outranks redirect, which outranks sequential.
  always_comb begin
    pc_d    = npc_q;
    npc_d   = npc_q + INC;
    do_push = 1'b0;
    do_pop  = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    take    = 1'b0;
    target  = redirect_target;
    if (le_pc) begin
      if (ret_pop) begin
        if (!ras_empty) begin
          do_pop = 1'b1;
          take   = 1'b1;
          target = ras_top;
        end else begin
          unf_d = 1'b1;
        end
      end else if (redirect_valid) begin
        take    = 1'b1;
        do_push = call_push;
        ovf_d   = call_push && ras_full;
      end
      if (take) begin
        if (redirect_delayed) begin
          npc_d = target;
        end else begin
          pc_d  = target;
          npc_d = target + INC;
        end
      end
    end
  end

  // PC/nPC, stack pointer/count and one-cycle pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + INC;
      ras_ptr <= '0;
      ras_cnt <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (le_pc) begin
        pc_q  <= pc_d;
        npc_q <= npc_d;
        if (do_push) begin
          ras_ptr <= ras_ptr + PTR_W'(1);
          if (!ras_full) ras_cnt <= ras_cnt + CNT_W'(1);
        end else if (do_pop) begin
          ras_ptr <= ras_ptr - PTR_W'(1);
          ras_cnt <= ras_cnt - CNT_W'(1);
        end
      end
    end
  end

  // Stack storage; a push into a full stack lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (!reset && do_push) ras_mem[ras_ptr + PTR_W'(1)] <= push_val;
  end

endmodule

// File: doc/pc_npc_unit.md
Name: pc_npc_unit

Overview:
- Parametrised successor to the single-register program counter.
- Holds a PC/nPC pair, which supports delayed-branch (delay-slot) and immediate redirects.
- Adds stall via the load enable and a small circular return-address stack (RAS) for call/return.
- Sits at the front of the fetch stage: pc_out drives instruction memory; redirects come from the branch/decode logic.

Parameters:
- WIDTH, 32, width of PC, nPC and all addresses.
- RESET_PC, 0, value loaded into PC on reset.
- INC, 4, byte increment per sequential instruction.
- RAS_DEPTH, 4, number of RAS entries (power of two, >=2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- le_pc  input  1  advance enable; 0 = stall (hold all state).
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  WIDTH  branch/jump target.
- redirect_delayed  input  1  1 = delayed (target goes to nPC), 0 = immediate (target goes to PC).
- call_push  input  1  with redirect_valid: push return address.
- ret_pop  input  1  return: redirect to RAS top.
- pc_out  output  WIDTH  current PC (registered).
- npc_out  output  WIDTH  next PC (registered).
- ras_top  output  WIDTH  top-of-stack value; 0 when empty.
- ras_count  output  $clog2(RAS_DEPTH)+1  valid entry count.
- ras_empty  output  1  ras_count==0.
- ras_full  output  1  ras_count==RAS_DEPTH.
- ras_overflow  output  1  one-cycle pulse: a push overwrote the oldest entry.
- ras_underflow  output  1  one-cycle pulse: pop attempted on an empty stack.

Behaviour:
- All state updates on posedge clk only. Registered outputs, zero combinational paths to pc_out/npc_out.
- Reset (highest priority, regardless of le_pc):
  - pc_out=RESET_PC, npc_out=RESET_PC+INC.
  - RAS cleared (count 0, pointer 0).
  - ras_overflow=0, ras_underflow=0.
- Stall (le_pc=0): PC, nPC and RAS hold. All request inputs are ignored. Pulse outputs go 0.
- With le_pc=1, the priority order is ret_pop > redirect_valid > sequential.
- Sequential: PC<=nPC; nPC<=nPC+INC.
- Delayed redirect with target T: PC<=nPC; nPC<=T.
- Immediate redirect with target T: PC<=T; nPC<=T+INC.
- ret_pop with RAS not empty:
  - T = ras_top. Applied delayed or immediate per redirect_delayed.
  - Pop: count-1, pointer-1 mod RAS_DEPTH.
  - redirect_valid and call_push are ignored that cycle.
- ret_pop with RAS empty: behaves as sequential; ras_underflow=1 for one cycle; RAS unchanged.
- call_push:
  - Effective only with redirect_valid=1 and ret_pop=0. call_push alone is ignored.
  - Pushed value = npc_out+INC (return past the delay slot), computed from pre-edge npc_out in both modes.
  - Push: write at pointer+1 mod RAS_DEPTH, pointer advances, count+1 saturating at RAS_DEPTH.
- Push when full: circular overwrite of the oldest entry; count stays RAS_DEPTH; ras_overflow=1 for one cycle.
- ras_top reflects the entry at the pointer combinationally from registered state; it updates the cycle after a push or pop.
- Arithmetic is modulo 2^WIDTH; nPC+INC wraps silently (e.g. 0xFFFFFFFC+4 = 0x00000000).
- Reset asserted mid-stall or coincident with any request: reset wins; requests are discarded.

Test Plan:
- Reset then 3 enabled cycles -> PC: 0,4,8,12; nPC: 4,8,12,16; ras_empty=1.
- At PC=8/nPC=12, delayed redirect T=0x100 -> next PC=12, nPC=0x100; following cycle PC=0x100, nPC=0x104.
- At PC=8/nPC=12, immediate redirect T=0x200 with call_push -> PC=0x200, nPC=0x204, ras_top=16, ras_count=1. Later ret_pop (immediate) -> PC=16, nPC=20, ras_empty=1.
- Five pushes of 0x10,0x20,0x30,0x40,0x50 into RAS_DEPTH=4 -> ras_overflow pulses on the 5th; count=4. Pops return 0x50,0x40,0x30,0x20; a fifth pop -> ras_underflow pulse, sequential advance.
- le_pc=0 for 3 cycles while redirect_valid=1, call_push=1 -> PC, nPC and ras_count unchanged. le_pc=1 resumes from the held values.
- nPC=0xFFFFFFFC sequential -> nPC wraps to 0. Reset asserted simultaneously with ret_pop and le_pc=0 -> PC=RESET_PC, nPC=RESET_PC+4, RAS cleared, no pulses.
